// File: rtl/stream_demultiplexer_if.sv
// Handshake bundle for stream_demultiplexer: one select-tagged input stream
// fanned out to CHANNELS independent valid/ready output streams.
interface stream_demultiplexer_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [WIDTH-1:0]          data_i;
  logic [SEL_W-1:0]          sel_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [CHANNELS*WIDTH-1:0] bus_o;
  logic [CHANNELS-1:0]       valid_o;
  logic [CHANNELS-1:0]       ready_i;
  logic                      drop_o;
  logic [15:0]               drop_count_o;

  // The demultiplexer itself is the slave side of this bundle.
  modport slave (
    input  data_i, sel_i, valid_i, ready_i,
    output ready_o, bus_o, valid_o, drop_o, drop_count_o
  );

  modport master (
    output data_i, sel_i, valid_i, ready_i,
    input  ready_o, bus_o, valid_o, drop_o, drop_count_o
  );
endinterface

// File: rtl/stream_demultiplexer.sv
// Registered 1-to-CHANNELS stream router: each accepted word lands in a one-entry
// register of the selected channel; illegal selects are accepted, dropped and counted.
module stream_demultiplexer #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  stream_demultiplexer_if.slave  dmx
);
  localparam int SEL_W = $clog2(CHANNELS);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t         state_q [CHANNELS];
  logic [WIDTH-1:0]    data_q  [CHANNELS];
  logic                drop_q;
  logic [15:0]         drop_count_q;

  logic                ready;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] drain;
  logic                drop_now;
  logic [CHANNELS-1:0]       valid_vec;
  logic [CHANNELS*WIDTH-1:0] bus_vec;

  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
    ready    = 1'b1;
    load     = '0;
    drain    = '0;
    drop_now = dmx.valid_i;
    for (int k = 0; k < CHANNELS; k++) begin
      drain[k] = (state_q[k] == FULL) && dmx.ready_i[k];
      if (dmx.sel_i == SEL_W'(k)) begin
        // Only the selected channel gates acceptance; an out-of-range select matches none.
        ready    = (state_q[k] == EMPTY) || dmx.ready_i[k];
        load[k]  = dmx.valid_i && ready;
        drop_now = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= EMPTY;
        // NOTE: the data registers are reset as well because bus_o must read zero out of reset.
        data_q[k]  <= '0;
      end
      drop_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      drop_q <= drop_now;
      if (drop_now && (drop_count_q != 16'hFFFF)) begin
        drop_count_q <= drop_count_q + 16'd1;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (load[k]) begin
          data_q[k]  <= dmx.data_i;
          state_q[k] <= FULL;
        end else if (drain[k]) begin
          state_q[k] <= EMPTY;
        end
      end
    end
  end

  // Channel 0 sits in the most significant slice of the packed bus.
  always_comb begin
    valid_vec = '0;
    bus_vec   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      valid_vec[k]                              = (state_q[k] == FULL);
      bus_vec[(CHANNELS-1-k)*WIDTH +: WIDTH]    = data_q[k];
    end
  end

  assign dmx.ready_o      = ready;
  assign dmx.valid_o      = valid_vec;
  assign dmx.bus_o        = bus_vec;
  assign dmx.drop_o       = drop_q;
  assign dmx.drop_count_o = drop_count_q;
endmodule

// File: tb/tb_stream_demultiplexer.sv
// Self-checking bench: directed cases on 4- and 3-channel instances, random soak on a
// 5-channel instance against a per-channel queue model.
module tb_stream_demultiplexer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  stream_demultiplexer_if #(.WIDTH(32), .CHANNELS(4)) if4 ();
  stream_demultiplexer_if #(.WIDTH(32), .CHANNELS(3)) if3 ();
  stream_demultiplexer_if #(.WIDTH(32), .CHANNELS(5)) if5 ();

  stream_demultiplexer #(.WIDTH(32), .CHANNELS(4)) u4 (.clk_i(clk), .rst_i(rst), .dmx(if4));
  stream_demultiplexer #(.WIDTH(32), .CHANNELS(3)) u3 (.clk_i(clk), .rst_i(rst), .dmx(if3));
  stream_demultiplexer #(.WIDTH(32), .CHANNELS(5)) u5 (.clk_i(clk), .rst_i(rst), .dmx(if5));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slice4(input int k);
    return if4.bus_o[(3-k)*32 +: 32];
  endfunction

  function automatic logic [31:0] slice5(input int k);
    return if5.bus_o[(4-k)*32 +: 32];
  endfunction

  // Reference model for the soak: words owed to each channel, in acceptance order.
  logic [31:0] model_q [5][$];
  int          model_drops = 0;
  bit          model_last_drop = 1'b0;

  task automatic soak_cycle(input bit force_idle);
    logic [4:0] exp_valid;
    bit         exp_ready;
    int         sel;
    @(negedge clk);
    if (force_idle) begin
      if5.valid_i = 1'b0;
      if5.sel_i   = 3'd0;
      if5.ready_i = 5'h1F;
    end else begin
      if5.valid_i = ($urandom_range(0, 9) < 7);
      if5.sel_i   = 3'($urandom_range(0, 7));
      if5.data_i  = $urandom;
      if5.ready_i = 5'($urandom_range(0, 31));
    end
    #1;
    check("soak_drop", if5.drop_o, model_last_drop);
    check("soak_drop_count", if5.drop_count_o, (model_drops > 65535) ? 65535 : model_drops);
    for (int k = 0; k < 5; k++) exp_valid[k] = (model_q[k].size() != 0);
    check("soak_valid", if5.valid_o, exp_valid);
    for (int k = 0; k < 5; k++) begin
      if (model_q[k].size() != 0) check("soak_data", slice5(k), model_q[k][0]);
    end
    sel = int'(if5.sel_i);
    exp_ready = (sel >= 5) ? 1'b1 : ((model_q[sel].size() == 0) || if5.ready_i[sel]);
    check("soak_ready", if5.ready_o, exp_ready);
    for (int k = 0; k < 5; k++) begin
      if ((model_q[k].size() != 0) && if5.ready_i[k]) void'(model_q[k].pop_front());
    end
    model_last_drop = 1'b0;
    if (if5.valid_i && exp_ready) begin
      if (sel >= 5) begin
        model_drops++;
        model_last_drop = 1'b1;
      end else begin
        model_q[sel].push_back(if5.data_i);
      end
    end
  endtask

  initial begin
    if4.data_i = '0; if4.sel_i = '0; if4.valid_i = 1'b0; if4.ready_i = '0;
    if3.data_i = '0; if3.sel_i = '0; if3.valid_i = 1'b0; if3.ready_i = '0;
    if5.data_i = '0; if5.sel_i = '0; if5.valid_i = 1'b0; if5.ready_i = '0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_valid", if4.valid_o, 4'b0000);
    check("rst_bus_zero", (if4.bus_o == '0), 1'b1);
    check("rst_drop_count", if4.drop_count_o, 16'd0);
    check("rst_drop", if4.drop_o, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Basic route to channel 2.
    if4.data_i = 32'hDEADBEEF; if4.sel_i = 2'd2; if4.valid_i = 1'b1; if4.ready_i = 4'b0000;
    #1 check("route_ready_empty", if4.ready_o, 1'b1);
    @(posedge clk); #1;
    if4.valid_i = 1'b0;
    check("route_valid", if4.valid_o, 4'b0100);
    check("route_bus", if4.bus_o[63:32], 32'hDEADBEEF);
    #1 check("route_ready_sel2", if4.ready_o, 1'b0);
    if4.sel_i = 2'd0;
    #1 check("route_ready_sel0", if4.ready_o, 1'b1);

    // Reset in the middle of a cycle while a word is held.
    rst = 1'b1;
    #1;
    check("midrst_valid", if4.valid_o, 4'b0000);
    check("midrst_bus_zero", (if4.bus_o == '0), 1'b1);
    @(negedge clk) rst = 1'b0;

    // Back-to-back on channel 1 with no bubble.
    if4.data_i = 32'h1; if4.sel_i = 2'd1; if4.valid_i = 1'b1; if4.ready_i = 4'b0000;
    @(posedge clk); #1;
    check("b2b_first_valid", if4.valid_o, 4'b0010);
    check("b2b_first_data", slice4(1), 32'h1);
    @(negedge clk);
    if4.data_i = 32'h2; if4.ready_i = 4'b0010;
    #1 check("b2b_ready_full", if4.ready_o, 1'b1);
    @(posedge clk); #1;
    check("b2b_reload_valid", if4.valid_o[1], 1'b1);
    check("b2b_reload_data", slice4(1), 32'h2);
    for (int w = 3; w <= 10; w++) begin
      @(negedge clk);
      if4.data_i = 32'(w);
      #1 check("stream_ready", if4.ready_o, 1'b1);
      @(posedge clk); #1;
      check("stream_valid", if4.valid_o, 4'b0010);
      check("stream_data", slice4(1), 32'(w));
    end
    @(negedge clk) if4.valid_i = 1'b0;
    @(posedge clk); #1;
    check("stream_drained", if4.valid_o, 4'b0000);

    // Independent channels: only channel 3 drains.
    @(negedge clk);
    if4.ready_i = 4'b0000; if4.valid_i = 1'b1; if4.sel_i = 2'd0; if4.data_i = 32'hA0A0A0A0;
    @(negedge clk);
    if4.sel_i = 2'd3; if4.data_i = 32'hA3A3A3A3;
    @(negedge clk);
    if4.valid_i = 1'b0;
    #1 check("indep_filled", if4.valid_o, 4'b1001);
    if4.ready_i = 4'b1000;
    @(posedge clk); #1;
    check("indep_only3_drains", if4.valid_o, 4'b0001);
    check("indep_ch0_holds", slice4(0), 32'hA0A0A0A0);
    @(negedge clk);
    if4.sel_i = 2'd0;
    #1 check("indep_sel0_blocked", if4.ready_o, 1'b0);
    if4.sel_i = 2'd3; if4.data_i = 32'hB3B3B3B3; if4.valid_i = 1'b1;
    #1 check("indep_sel3_ready", if4.ready_o, 1'b1);
    @(posedge clk); #1;
    check("indep_reload_valid", if4.valid_o, 4'b1001);
    check("indep_reload_data", slice4(3), 32'hB3B3B3B3);
    check("indep_ch0_still", slice4(0), 32'hA0A0A0A0);
    @(negedge clk);
    if4.valid_i = 1'b0; if4.ready_i = 4'b1111;
    @(posedge clk); #1;
    check("indep_all_drained", if4.valid_o, 4'b0000);

    fork
      begin
        // Illegal select on the 3-channel instance, then saturate the counter.
        @(negedge clk);
        if3.sel_i = 2'd3; if3.valid_i = 1'b1; if3.data_i = 32'h55;
        #1 check("illegal_ready", if3.ready_o, 1'b1);
        @(posedge clk); #1;
        check("illegal_drop_pulse", if3.drop_o, 1'b1);
        check("illegal_count_one", if3.drop_count_o, 16'd1);
        check("illegal_valid_unchanged", if3.valid_o, 3'b000);
        @(negedge clk) if3.valid_i = 1'b0;
        @(posedge clk); #1;
        check("illegal_drop_ends", if3.drop_o, 1'b0);
        check("illegal_count_holds", if3.drop_count_o, 16'd1);
        @(negedge clk) if3.valid_i = 1'b1;
        repeat (69999) @(posedge clk);
        @(negedge clk) if3.valid_i = 1'b0;
        #1;
        check("drop_count_saturated", if3.drop_count_o, 16'hFFFF);
        check("drop_valid_unchanged", if3.valid_o, 3'b000);
      end
      begin
        for (int cyc = 0; cyc < 10000; cyc++) soak_cycle(1'b0);
        soak_cycle(1'b1);
        soak_cycle(1'b1);
        begin
          int left = 0;
          for (int k = 0; k < 5; k++) left += model_q[k].size();
          check("soak_all_delivered", left, 0);
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
